// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants and types for the ALU arbiter slice: ALU op
//               encodings, flag bit positions, datapath widths and the
//               arbiter state type.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU operation encodings, passed through to ALUControl untouched
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_XOR = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    // Bit positions inside the 4-bit {carry, overflow, negative, zero} flag word
    localparam int FLG_ZERO  = 0;
    localparam int FLG_NEG   = 1;
    localparam int FLG_OVF   = 2;
    localparam int FLG_CARRY = 3;

    // Datapath widths shared by interface, arbiter and bench
    localparam int DATA_W = 32;
    localparam int FLAG_W = 4;
    localparam int OP_W   = 2;

    // Arbiter transaction phases: accept, drive the ALU, hold the response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Bundle of the requester, ALU and response buses around the
//               ALU arbiter. The master side is the requesters plus the ALU
//               and the response consumer; the slave side is the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);

    // Requester side
    logic [NREQ-1:0]                           req_valid;
    logic [NREQ-1:0]                           req_ready;
    logic [NREQ-1:0][alu_pkg::DATA_W-1:0]      req_a;
    logic [NREQ-1:0][alu_pkg::DATA_W-1:0]      req_b;
    logic [NREQ-1:0][alu_pkg::OP_W-1:0]        req_op;

    // Shared combinational ALU
    logic [alu_pkg::DATA_W-1:0]                alu_a;
    logic [alu_pkg::DATA_W-1:0]                alu_b;
    logic [alu_pkg::OP_W-1:0]                  alu_ctrl;
    logic [alu_pkg::DATA_W-1:0]                alu_out;
    logic [alu_pkg::FLAG_W-1:0]                alu_flags;

    // Response side
    logic                                      rsp_valid;
    logic                                      rsp_ready;
    logic [IDW-1:0]                            rsp_id;
    logic [alu_pkg::DATA_W-1:0]                rsp_data;
    logic [alu_pkg::FLAG_W-1:0]                rsp_flags;

    // Requesters, ALU and response consumer
    modport master (
        output req_valid, req_a, req_b, req_op,
        input  req_ready,
        input  alu_a, alu_b, alu_ctrl,
        output alu_out, alu_flags,
        input  rsp_valid, rsp_id, rsp_data, rsp_flags,
        output rsp_ready
    );

    // Arbiter
    modport slave (
        input  req_valid, req_a, req_b, req_op,
        output req_ready,
        output alu_a, alu_b, alu_ctrl,
        input  alu_out, alu_flags,
        output rsp_valid, rsp_id, rsp_data, rsp_flags,
        input  rsp_ready
    );

endinterface : alu_arbiter_if
`default_nettype wire

// File: rtl/alu_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first asserted
//               valid bit at or after the pointer, wrapping modulo NREQ, as a
//               one-hot grant, a binary index and an any-valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  wire logic [NREQ-1:0] i_valid,
    input  wire logic [IDW-1:0]  i_ptr,
    output logic      [NREQ-1:0] o_grant,
    output logic      [IDW-1:0]  o_idx,
    output logic                 o_any
);

    logic [IDW-1:0] w_idx;
    logic           w_found;

    // Two passes give the wrap: indices at/after the pointer first, then the
    // ones below it. The first hit in the scan order wins.
    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_valid[i] && (i >= int'(i_ptr))) begin
                w_found = 1'b1;
                w_idx   = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_valid[i] && (i < int'(i_ptr))) begin
                w_found = 1'b1;
                w_idx   = IDW'(i);
            end
        end
    end

    // Expand the winning index into a one-hot grant
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_grant
            assign o_grant[gi] = w_found && (w_idx == IDW'(gi));
        end
    endgenerate

    assign o_idx = w_idx;
    assign o_any = w_found;

endmodule : rr_pick
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational ALU between NREQ requesters.
//               Round-robin grant in IDLE, registered ALU drive in EXEC,
//               registered result/flags held in RESP until consumed. One
//               transaction in flight; the arbiter does no arithmetic itself.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  wire logic    clk,
    input  wire logic    reset,
    alu_arbiter_if.slave bus
);

    arb_state_t          r_state;
    logic [IDW-1:0]      r_ptr;
    logic [IDW-1:0]      r_id;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [OP_W-1:0]     r_alu_ctrl;
    logic                r_rsp_valid;
    logic [IDW-1:0]      r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [FLAG_W-1:0]   r_rsp_flags;

    logic [NREQ-1:0]     w_grant;
    logic [IDW-1:0]      w_idx;
    logic                w_any;
    logic                w_accept;
    logic [IDW-1:0]      w_ptr_next;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .i_valid (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Accept only from IDLE; reset masks the grant so a pending request
    // never sees a ready pulse that the state register will not honour.
    assign w_accept      = (r_state == IDLE) && w_any && !reset;
    assign bus.req_ready = w_accept ? w_grant : '0;

    // Pointer moves one past the requester just served, wrapping at NREQ
    assign w_ptr_next = (r_id == IDW'(NREQ - 1)) ? '0 : (r_id + IDW'(1));

    // Transaction FSM with registered ALU drive and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_ctrl  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Operand registers double as the ALU drive, so the ALU
                    // inputs only change on a clock edge.
                    if (w_any) begin
                        r_alu_a    <= bus.req_a[w_idx];
                        r_alu_b    <= bus.req_b[w_idx];
                        r_alu_ctrl <= bus.req_op[w_idx];
                        r_id       <= w_idx;
                        r_state    <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU has had a full cycle on stable inputs; capture it
                    // and park its inputs at zero again.
                    r_rsp_data  <= bus.alu_out;
                    r_rsp_flags <= bus.alu_flags;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_alu_a     <= '0;
                    r_alu_b     <= '0;
                    r_alu_ctrl  <= '0;
                    r_state     <= RESP;
                end
                RESP: begin
                    // Response is held untouched until the consumer takes it;
                    // fairness advances only on a completed transaction.
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= w_ptr_next;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_ctrl  = r_alu_ctrl;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_flags = r_rsp_flags;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter with a behavioural ALU
//               behind it and a round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_arbiter_if #(.NREQ(N)) bus ();

    alu_arbiter #(.NREQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {carry, ovf, neg, zero, result}
    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        lt;
        c  = 1'b0;
        v  = 1'b0;
        s  = '0;
        lt = ($signed(a) < $signed(b));
        case (op)
            ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            ALU_XOR: r = a ^ b;
            ALU_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0];
                c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            default: r = {31'd0, lt};
        endcase
        return {c, v, r[31], (r == 32'd0), r};
    endfunction

    // Real ALU behaviour sitting behind the arbiter
    always_comb {bus.alu_flags, bus.alu_out} = alu_ref(bus.alu_a, bus.alu_b, bus.alu_ctrl);

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic obs();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        drive_edge();
        reset         = 1'b1;
        bus.req_valid = '0;
        drive_edge();
        drive_edge();
        reset = 1'b0;
    endtask

    task automatic new_payload(input int j);
        bus.req_a[j]  = $urandom;
        bus.req_b[j]  = ($urandom_range(0, 3) == 0) ? bus.req_a[j] : 32'($urandom);
        bus.req_op[j] = 2'($urandom_range(0, 3));
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        repeat (2) drive_edge();
        obs();
        n_cmp++;
        if (bus.req_ready !== '0) begin
            n_err++;
            $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready);
        end
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_flags} !== '0) begin
            n_err++;
            $display("FAIL reset_rsp got valid=%b id=%h data=%h flags=%b exp all 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_flags);
        end
        n_cmp++;
        if ({bus.alu_a, bus.alu_b, bus.alu_ctrl} !== '0) begin
            n_err++;
            $display("FAIL reset_alu got a=%h b=%h ctrl=%b exp all 0",
                     bus.alu_a, bus.alu_b, bus.alu_ctrl);
        end
        drive_edge();
        reset         = 1'b0;
        bus.req_valid = '0;
    endtask

    task automatic test_ops();
        int          tid [5] = '{0, 1, 1, 0, 0};
        logic [1:0]  top [5] = '{ALU_ADD, ALU_SUB, ALU_SUB, ALU_ADD, ALU_SLT};
        logic [31:0] ta  [5] = '{32'd5, 32'd3, 32'd9, 32'h7FFF_FFFF, 32'hFFFF_FFFC};
        logic [31:0] tb  [5] = '{32'd7, 32'd5, 32'd9, 32'd1, 32'd2};
        logic [31:0] td  [5] = '{32'd12, 32'hFFFF_FFFE, 32'd0, 32'h8000_0000, 32'd1};
        logic [3:0]  tf  [5] = '{4'b0000, 4'b0010, 4'b1001, 4'b0110, 4'b0000};
        logic [N-1:0] eo;
        logic [0:0]   eid;
        int           k;
        for (int t = 0; t < 5; t++) begin
            drive_edge();
            bus.req_valid          = '0;
            bus.req_valid[tid[t]]  = 1'b1;
            bus.req_a[tid[t]]      = ta[t];
            bus.req_b[tid[t]]      = tb[t];
            bus.req_op[tid[t]]     = top[t];
            bus.rsp_ready          = 1'b1;
            k = 0;
            do begin
                obs();
                k++;
            end while (bus.req_ready === '0 && k < 8);
            eo         = '0;
            eo[tid[t]] = 1'b1;
            eid        = tid[t][0];
            n_cmp++;
            if (bus.req_ready !== eo) begin
                n_err++;
                $display("FAIL ops%0d_grant got=%b exp=%b", t, bus.req_ready, eo);
            end
            drive_edge();
            bus.req_valid = '0;
            obs();
            n_cmp++;
            if ({bus.alu_ctrl, bus.alu_a, bus.alu_b} !== {top[t], ta[t], tb[t]}) begin
                n_err++;
                $display("FAIL ops%0d_alu_drive got ctrl=%b a=%h b=%h exp ctrl=%b a=%h b=%h",
                         t, bus.alu_ctrl, bus.alu_a, bus.alu_b, top[t], ta[t], tb[t]);
            end
            drive_edge();
            obs();
            n_cmp++;
            if ({bus.rsp_valid, bus.rsp_id} !== {1'b1, eid}) begin
                n_err++;
                $display("FAIL ops%0d_rsp_valid_id got valid=%b id=%h exp valid=1 id=%h",
                         t, bus.rsp_valid, bus.rsp_id, eid);
            end
            n_cmp++;
            if (bus.rsp_data !== td[t]) begin
                n_err++;
                $display("FAIL ops%0d_data got=%h exp=%h", t, bus.rsp_data, td[t]);
            end
            n_cmp++;
            if (bus.rsp_flags !== tf[t]) begin
                n_err++;
                $display("FAIL ops%0d_flags got=%b exp=%b", t, bus.rsp_flags, tf[t]);
            end
            drive_edge();
            obs();
            n_cmp++;
            if ({bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_ctrl} !== '0) begin
                n_err++;
                $display("FAIL ops%0d_after got valid=%b a=%h b=%h ctrl=%b exp all 0",
                         t, bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_ctrl);
            end
        end
    endtask

    task automatic test_round_robin();
        int           order [6] = '{-1, -1, -1, -1, -1, -1};
        int           mptr = 0;
        int           ngr  = 0;
        int           nrsp = 0;
        int           acc;
        int           exp_id = 0;
        logic [35:0]  exp_r  = '0;
        logic [N-1:0] eo;
        apply_reset();
        bus.rsp_ready = 1'b1;
        for (int j = 0; j < N; j++) new_payload(j);
        bus.req_valid = '1;
        for (int c = 0; c < 80 && nrsp < 6; c++) begin
            obs();
            acc = -1;
            if (bus.req_ready !== '0) begin
                eo       = '0;
                eo[mptr] = 1'b1;
                n_cmp++;
                if (bus.req_ready !== eo) begin
                    n_err++;
                    $display("FAIL rr_grant got=%b exp=%b", bus.req_ready, eo);
                end
                acc = (bus.req_ready[1] === 1'b1) ? 1 : 0;
                if (ngr < 6) order[ngr] = acc;
                ngr++;
                exp_id = mptr;
                exp_r  = alu_ref(bus.req_a[mptr], bus.req_b[mptr], bus.req_op[mptr]);
            end
            if (bus.rsp_valid === 1'b1) begin
                n_cmp++;
                if ({bus.rsp_id, bus.rsp_flags, bus.rsp_data} !== {exp_id[0], exp_r}) begin
                    n_err++;
                    $display("FAIL rr_rsp got id=%h flags=%b data=%h exp id=%0d flags=%b data=%h",
                             bus.rsp_id, bus.rsp_flags, bus.rsp_data, exp_id,
                             exp_r[35:32], exp_r[31:0]);
                end
                nrsp++;
                mptr = (exp_id + 1) % N;
            end
            drive_edge();
            if (acc >= 0) new_payload(acc);
        end
        n_cmp++;
        if (nrsp != 6) begin
            n_err++;
            $display("FAIL rr_count got=%0d responses exp=6", nrsp);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (order[i] != (i % 2)) begin
                n_err++;
                $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, order[i], i % 2);
            end
        end
        drive_edge();
        bus.req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [35:0] exp_r;
        logic [31:0] hold_data;
        logic [3:0]  hold_flags;
        int          k;
        apply_reset();
        new_payload(0);
        new_payload(1);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b0;
        exp_r = alu_ref(bus.req_a[0], bus.req_b[0], bus.req_op[0]);
        obs();
        n_cmp++;
        if (bus.req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL bp_first_grant got=%b exp=01", bus.req_ready);
        end
        drive_edge();
        bus.req_valid = 2'b10;
        k = 0;
        do begin
            obs();
            k++;
        end while (bus.rsp_valid !== 1'b1 && k < 6);
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_flags, bus.rsp_data} !== {1'b1, 1'b0, exp_r}) begin
            n_err++;
            $display("FAIL bp_rsp got valid=%b id=%h flags=%b data=%h exp valid=1 id=0 flags=%b data=%h",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_flags, bus.rsp_data,
                     exp_r[35:32], exp_r[31:0]);
        end
        hold_data  = exp_r[31:0];
        hold_flags = exp_r[35:32];
        for (int i = 0; i < 5; i++) begin
            drive_edge();
            obs();
            n_cmp++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_flags, bus.rsp_data, bus.req_ready} !==
                {1'b1, 1'b0, hold_flags, hold_data, 2'b00}) begin
                n_err++;
                $display("FAIL bp_stall%0d got valid=%b id=%h flags=%b data=%h ready=%b exp stable, ready=00",
                         i, bus.rsp_valid, bus.rsp_id, bus.rsp_flags, bus.rsp_data, bus.req_ready);
            end
        end
        drive_edge();
        bus.rsp_ready = 1'b1;
        obs();
        drive_edge();
        bus.rsp_ready = 1'b0;
        obs();
        n_cmp++;
        if ({bus.rsp_valid, bus.req_ready} !== {1'b0, 2'b10}) begin
            n_err++;
            $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=10",
                     bus.rsp_valid, bus.req_ready);
        end
        exp_r = alu_ref(bus.req_a[1], bus.req_b[1], bus.req_op[1]);
        drive_edge();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        obs();
        drive_edge();
        obs();
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_flags, bus.rsp_data} !== {1'b1, 1'b1, exp_r}) begin
            n_err++;
            $display("FAIL bp_second_rsp got valid=%b id=%h flags=%b data=%h exp valid=1 id=1 flags=%b data=%h",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_flags, bus.rsp_data,
                     exp_r[35:32], exp_r[31:0]);
        end
        drive_edge();
    endtask

    task automatic test_reset_in_exec();
        logic [31:0] a1;
        int          k;
        apply_reset();
        bus.rsp_ready = 1'b1;
        new_payload(0);
        bus.req_valid = 2'b01;
        obs();
        drive_edge();
        bus.req_valid = '0;
        k = 0;
        do begin
            obs();
            k++;
        end while (bus.rsp_valid !== 1'b1 && k < 6);
        drive_edge();
        new_payload(0);
        new_payload(1);
        a1            = bus.req_a[1];
        bus.req_valid = 2'b11;
        obs();
        n_cmp++;
        if (bus.req_ready !== 2'b10) begin
            n_err++;
            $display("FAIL rx_pre_grant got=%b exp=10", bus.req_ready);
        end
        drive_edge();
        reset = 1'b1;
        obs();
        n_cmp++;
        if (bus.alu_a !== a1) begin
            n_err++;
            $display("FAIL rx_in_exec got a=%h exp=%h", bus.alu_a, a1);
        end
        drive_edge();
        obs();
        n_cmp++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_flags,
             bus.alu_a, bus.alu_b, bus.alu_ctrl} !== '0) begin
            n_err++;
            $display("FAIL rx_cleared got ready=%b valid=%b id=%h data=%h flags=%b a=%h b=%h ctrl=%b exp all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_flags,
                     bus.alu_a, bus.alu_b, bus.alu_ctrl);
        end
        drive_edge();
        reset = 1'b0;
        obs();
        n_cmp++;
        if ({bus.req_ready, bus.rsp_valid} !== {2'b01, 1'b0}) begin
            n_err++;
            $display("FAIL rx_regrant got ready=%b valid=%b exp ready=01 valid=0",
                     bus.req_ready, bus.rsp_valid);
        end
        drive_edge();
        bus.req_valid = '0;
        repeat (3) drive_edge();
    endtask

    task automatic test_random();
        int           mptr   = 0;
        int           busy   = 0;
        int           acc_c  = 0;
        int           exp_id = 0;
        int           nrsp   = 0;
        int           eg;
        int           acc;
        int           j;
        logic         erv;
        logic [35:0]  exp_r  = '0;
        logic [N-1:0] eo;
        apply_reset();
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            obs();
            acc = -1;
            if (busy != 0) begin
                n_cmp++;
                if (bus.req_ready !== '0) begin
                    n_err++;
                    $display("FAIL rand_ready_busy c=%0d got=%b exp=00", c, bus.req_ready);
                end
            end else begin
                eg = -1;
                for (int k = 0; k < N; k++) begin
                    j = (mptr + k) % N;
                    if (eg < 0 && bus.req_valid[j] === 1'b1) eg = j;
                end
                eo = '0;
                if (eg >= 0) eo[eg] = 1'b1;
                n_cmp++;
                if (bus.req_ready !== eo) begin
                    n_err++;
                    $display("FAIL rand_grant c=%0d got=%b exp=%b", c, bus.req_ready, eo);
                end
                if (eg >= 0) begin
                    busy   = 1;
                    exp_id = eg;
                    exp_r  = alu_ref(bus.req_a[eg], bus.req_b[eg], bus.req_op[eg]);
                    acc_c  = c;
                    acc    = eg;
                end
            end
            erv = (busy != 0) && (c >= acc_c + 2);
            n_cmp++;
            if (bus.rsp_valid !== erv) begin
                n_err++;
                $display("FAIL rand_rsp_valid c=%0d got=%b exp=%b", c, bus.rsp_valid, erv);
            end
            if (erv && bus.rsp_valid === 1'b1) begin
                n_cmp++;
                if ({bus.rsp_id, bus.rsp_flags, bus.rsp_data} !== {exp_id[0], exp_r}) begin
                    n_err++;
                    $display("FAIL rand_rsp c=%0d got id=%h flags=%b data=%h exp id=%0d flags=%b data=%h",
                             c, bus.rsp_id, bus.rsp_flags, bus.rsp_data, exp_id,
                             exp_r[35:32], exp_r[31:0]);
                end
                if (bus.rsp_ready === 1'b1) begin
                    busy = 0;
                    mptr = (exp_id + 1) % N;
                    nrsp++;
                end
            end
            drive_edge();
            for (int r = 0; r < N; r++) begin
                if (acc == r) begin
                    bus.req_valid[r] = 1'b0;
                end else if (bus.req_valid[r] == 1'b0) begin
                    if ($urandom_range(0, 1) == 1) begin
                        new_payload(r);
                        bus.req_valid[r] = 1'b1;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    bus.req_valid[r] = 1'b0;
                end
            end
            bus.rsp_ready = ($urandom_range(0, 2) != 0);
        end
        n_cmp++;
        if (nrsp < 20) begin
            n_err++;
            $display("FAIL rand_throughput got=%0d responses exp>=20", nrsp);
        end
        drive_edge();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) drive_edge();
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_ops();
        test_round_robin();
        test_backpressure();
        test_reset_in_exec();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule : tb_alu_arbiter
`default_nettype wire
